// File: rtl/tpu_pkg.sv
// Shared types and constants for the MAC sequencer and its neighbours.
// The state enum, the NOP operand and the datapath widths live here.
package tpu_pkg;

  localparam int unsigned LEN_W_DEF = 8;
  localparam int unsigned OP_W      = 8;
  localparam int unsigned RES_W     = 32;
  localparam int unsigned HALF_W    = 16;

  // An all-zero minifloat pair multiplies to exactly zero in the MAC
  localparam logic [OP_W-1:0] MAC_NOP = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_DRAIN,
    ST_READ_LO,
    ST_READ_HI,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/mac_sequencer.sv
// Runs one dot-product job through an external MAC: clear, stream N operand
// pairs, drain the pipeline, then read the 32-bit accumulator as two halves.
module mac_sequencer
  import tpu_pkg::*;
#(
  parameter int unsigned LEN_W = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              start_ready,
  input  logic              op_valid,
  input  logic [OP_W-1:0]   op_a,
  input  logic [OP_W-1:0]   op_b,
  output logic              op_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic              busy,
  output logic              mac_reset,
  output logic [OP_W-1:0]   mac_a,
  output logic [OP_W-1:0]   mac_b,
  output logic              mac_out_hl,
  input  logic [HALF_W-1:0] mac_out
);

  seq_state_e        r_state;
  logic [LEN_W-1:0]  r_count;
  logic              r_mac_reset;
  logic [OP_W-1:0]   r_mac_a;
  logic [OP_W-1:0]   r_mac_b;
  logic              r_mac_out_hl;
  logic              r_res_valid;
  logic [RES_W-1:0]  r_res_data;

  // Handshake readiness and busy are decoded straight from the state
  assign start_ready = (r_state == ST_IDLE) && !reset;
  assign op_ready    = (r_state == ST_RUN);
  assign busy        = (r_state != ST_IDLE);

  assign mac_reset  = r_mac_reset;
  assign mac_a      = r_mac_a;
  assign mac_b      = r_mac_b;
  assign mac_out_hl = r_mac_out_hl;
  assign res_valid  = r_res_valid;
  assign res_data   = r_res_data;

  // Sequencer FSM; MAC controls default to idle values every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_count      <= '0;
      r_mac_reset  <= 1'b1;
      r_mac_a      <= MAC_NOP;
      r_mac_b      <= MAC_NOP;
      r_mac_out_hl <= 1'b1;
      r_res_valid  <= 1'b0;
      r_res_data   <= '0;
    end else begin
      r_mac_reset  <= 1'b0;
      r_mac_a      <= MAC_NOP;
      r_mac_b      <= MAC_NOP;
      r_mac_out_hl <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_count     <= len;
            r_mac_reset <= 1'b1;
            r_state     <= ST_CLEAR;
          end
        end

        ST_CLEAR: begin
          r_state <= (r_count == '0) ? ST_DRAIN : ST_RUN;
        end

        ST_RUN: begin
          if (op_valid) begin
            r_mac_a <= op_a;
            r_mac_b <= op_b;
            r_count <= r_count - LEN_W'(1);
            if (r_count == LEN_W'(1)) begin
              r_state <= ST_DRAIN;
            end
          end
        end

        // Last pair is being accumulated; select the low half for the read
        ST_DRAIN: begin
          r_mac_out_hl <= 1'b0;
          r_state      <= ST_READ_LO;
        end

        ST_READ_LO: begin
          r_res_data[HALF_W-1:0] <= mac_out;
          r_state                <= ST_READ_HI;
        end

        ST_READ_HI: begin
          r_res_data[RES_W-1:HALF_W] <= mac_out;
          r_res_valid                <= 1'b1;
          r_state                    <= ST_DONE;
        end

        ST_DONE: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with a behavioural minifloat MAC attached.
module tb_mac_sequencer;
  import tpu_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [7:0]        len;
  logic              start_ready;
  logic              op_valid;
  logic [7:0]        op_a, op_b;
  logic              op_ready;
  logic              res_valid;
  logic              res_ready;
  logic [31:0]       res_data;
  logic              busy;
  logic              mac_reset;
  logic [7:0]        mac_a, mac_b;
  logic              mac_out_hl;
  logic [15:0]       mac_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] va [8];
  logic [7:0] vb [8];

  always #5 clk = ~clk;

  mac_sequencer #(.LEN_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .start_ready(start_ready), .op_valid(op_valid), .op_a(op_a), .op_b(op_b),
    .op_ready(op_ready), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .busy(busy), .mac_reset(mac_reset), .mac_a(mac_a),
    .mac_b(mac_b), .mac_out_hl(mac_out_hl), .mac_out(mac_out)
  );

  // Minifloat value: {1,m} << (e-1) for e>0, m for e==0, sign applied last
  function automatic logic signed [31:0] mf_val(input logic [7:0] x);
    logic [3:0]  e;
    logic [31:0] mag;
    e = x[6:3];
    if (e == 4'd0) mag = 32'(x[2:0]);
    else           mag = 32'({1'b1, x[2:0]}) << (e - 4'd1);
    return x[7] ? -$signed(mag) : $signed(mag);
  endfunction

  logic [31:0] acc;
  always @(posedge clk) begin
    if (mac_reset) acc <= 32'd0;
    else           acc <= acc + 32'(mf_val(mac_a) * mf_val(mac_b));
  end
  assign mac_out = mac_out_hl ? acc[31:16] : acc[15:0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a job at cycle 0; bit i of mask inserts one stall before pair i
  task automatic do_job(input int n, input logic [7:0] mask, input string tag,
                        output int lat, output logic [31:0] res);
    int   i;
    int   c;
    logic gap_prev;
    logic hl_hist [64];
    i = 0;
    gap_prev = 1'b0;
    lat = -1;
    res = '0;
    start = 1'b1;
    len   = 8'(n);
    chk({tag, "/start_ready"}, 32'(start_ready), 32'd1);
    tick();
    start = 1'b0;
    c = 1;
    chk({tag, "/clear_mac_reset"}, 32'(mac_reset), 32'd1);
    while (c < 60) begin
      hl_hist[c] = mac_out_hl;
      if (c == 2) chk({tag, "/mac_reset_low"}, 32'(mac_reset), 32'd0);
      if (gap_prev) chk({tag, "/gap_nop"}, {16'd0, mac_a, mac_b}, 32'd0);
      gap_prev = 1'b0;
      if (res_valid) begin
        lat = c;
        res = res_data;
        break;
      end
      op_valid = 1'b0;
      op_a = 8'h7F;
      op_b = 8'h7F;
      if (op_ready && i < n) begin
        if (mask[i]) begin
          mask[i]  = 1'b0;
          gap_prev = 1'b1;
        end else begin
          op_valid = 1'b1;
          op_a = va[i];
          op_b = vb[i];
          i++;
        end
      end else if (c == 1) begin
        op_valid = 1'b1;
      end
      tick();
      c++;
    end
    op_valid = 1'b0;
    if (lat < 0) begin
      chk({tag, "/timeout"}, 32'd0, 32'd1);
      lat = 0;
    end else begin
      chk({tag, "/hl_read_lo"}, 32'(hl_hist[lat-2]), 32'd0);
      chk({tag, "/hl_read_hi"}, 32'(hl_hist[lat-1]), 32'd1);
    end
  endtask

  task automatic chk_idle_after(input string tag);
    tick();
    chk({tag, "/res_valid_drop"}, 32'(res_valid), 32'd0);
    chk({tag, "/busy_drop"}, 32'(busy), 32'd0);
    chk({tag, "/start_ready"}, 32'(start_ready), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] res;
    logic [7:0]  mask;

    reset = 1'b1; start = 1'b0; len = '0; op_valid = 1'b0;
    op_a = '0; op_b = '0; res_ready = 1'b1;
    tick(); tick();
    chk("rst/mac_reset", 32'(mac_reset), 32'd1);
    chk("rst/mac_ab", {16'd0, mac_a, mac_b}, 32'd0);
    chk("rst/hl", 32'(mac_out_hl), 32'd1);
    chk("rst/res_valid", 32'(res_valid), 32'd0);
    chk("rst/res_data", res_data, 32'd0);
    chk("rst/busy", 32'(busy), 32'd0);
    chk("rst/start_ready", 32'(start_ready), 32'd0);
    chk("rst/op_ready", 32'(op_ready), 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst/mac_reset", 32'(mac_reset), 32'd0);
    chk("post_rst/start_ready", 32'(start_ready), 32'd1);

    // N=3, 8*8 three times
    va[0] = 8'h08; vb[0] = 8'h08; va[1] = 8'h08; vb[1] = 8'h08;
    va[2] = 8'h08; vb[2] = 8'h08;
    do_job(3, 8'h00, "n3", lat, res);
    chk("n3/res", res, 32'h0000_00C0);
    chk("n3/lat", 32'(lat), 32'd8);
    chk_idle_after("n3");

    va[0] = 8'h88; vb[0] = 8'h08; va[1] = 8'h08; vb[1] = 8'h08;
    do_job(2, 8'h00, "n2", lat, res);
    chk("n2/res", res, 32'h0000_0000);
    chk("n2/lat", 32'(lat), 32'd7);
    chk_idle_after("n2");

    va[0] = 8'h88; vb[0] = 8'h08;
    do_job(1, 8'h00, "n1neg", lat, res);
    chk("n1neg/res", res, 32'hFFFF_FFC0);
    chk("n1neg/lat", 32'(lat), 32'd6);
    chk_idle_after("n1neg");

    va[0] = 8'h50; vb[0] = 8'h50;
    do_job(1, 8'h00, "n1hi", lat, res);
    chk("n1hi/res", res, 32'h0100_0000);
    chk_idle_after("n1hi");
    chk("n1hi/res_hold_idle", res_data, 32'h0100_0000);

    // Abort a 5-pair job after two pairs
    start = 1'b1; len = 8'd5;
    tick();
    start = 1'b0;
    tick();
    op_valid = 1'b1; op_a = 8'h50; op_b = 8'h50;
    tick();
    op_valid = 1'b1; op_a = 8'h50; op_b = 8'h50;
    tick();
    op_valid = 1'b0;
    chk("abort/busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    chk("abort/busy", 32'(busy), 32'd0);
    chk("abort/mac_reset", 32'(mac_reset), 32'd1);
    chk("abort/mac_ab", {16'd0, mac_a, mac_b}, 32'd0);
    chk("abort/hl", 32'(mac_out_hl), 32'd1);
    chk("abort/res_data", res_data, 32'd0);
    chk("abort/res_valid", 32'(res_valid), 32'd0);
    chk("abort/start_ready", 32'(start_ready), 32'd0);
    reset = 1'b0;
    tick();
    chk("abort/mac_reset_low", 32'(mac_reset), 32'd0);

    va[0] = 8'h08; vb[0] = 8'h08;
    do_job(1, 8'h00, "after_abort", lat, res);
    chk("after_abort/res", res, 32'h0000_0040);
    chk("after_abort/lat", 32'(lat), 32'd6);
    chk_idle_after("after_abort");

    // N=4 with three stalls placed at random pair positions
    va[0] = 8'h08; vb[0] = 8'h08; va[1] = 8'h08; vb[1] = 8'h10;
    va[2] = 8'h88; vb[2] = 8'h08; va[3] = 8'h10; vb[3] = 8'h10;
    mask = 8'h0F & ~(8'h01 << $urandom_range(0, 3));
    do_job(4, mask, "stall", lat, res);
    chk("stall/res", res, 32'h0000_0180);
    chk("stall/lat", 32'(lat), 32'd12);
    chk_idle_after("stall");

    // N=0 with the result held off for ten cycles
    res_ready = 1'b0;
    do_job(0, 8'h00, "n0", lat, res);
    chk("n0/res", res, 32'd0);
    chk("n0/lat", 32'(lat), 32'd5);
    for (int k = 0; k < 10; k++) begin
      start = 1'b1;
      len   = 8'd3;
      tick();
      chk("hold/res_valid", 32'(res_valid), 32'd1);
      chk("hold/res_data", res_data, 32'd0);
      chk("hold/start_ready", 32'(start_ready), 32'd0);
      chk("hold/busy", 32'(busy), 32'd1);
    end
    start = 1'b0;
    res_ready = 1'b1;
    chk_idle_after("hold");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_sequencer.md
# mac_sequencer

Sequences one dot-product job through the 8-bit MAC (multiply-accumulate) unit. Each operand is an 8-bit minifloat: sign, 4-bit exponent, 3-bit mantissa. The block takes a job of length N from the host, clears the MAC accumulator, and streams N operand pairs into the MAC with a valid/ready handshake. It then reads the 32-bit accumulator back through the MAC's 16-bit half-select port and returns it on a result handshake. It sits between the host/operand buffer and a single MAC instance, and is the only driver of that MAC's control and operand inputs.

## Interface
Parameters:
- LEN_W, 8, width of the job length (max N = 2^LEN_W-1)

Ports:
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  synchronous, active-high; returns the block to IDLE
- start  in  1  job request
- len  in  LEN_W  number of operand pairs; sampled when start is accepted
- start_ready  out  1  high only in IDLE and not in reset
- op_valid  in  1  operand pair valid
- op_a, op_b  in  8  operand pair
- op_ready  out  1  high only in RUN
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_data  out  32  accumulated sum, two's complement
- busy  out  1  state != IDLE
- mac_reset  out  1  to the MAC reset input
- mac_a, mac_b  out  8  to the MAC operand inputs
- mac_out_hl  out  1  MAC half select; 0 selects the low half, 1 the high half
- mac_out  in  16  MAC selected half

## Operation
- States: IDLE, CLEAR, RUN, DRAIN, READ_LO, READ_HI, DONE.
- IDLE: start accepted when start && start_ready. Latch len into the remaining-count register, then go to CLEAR.
- CLEAR: one cycle with mac_reset=1. If count==0 go to DRAIN, else go to RUN.
- RUN:
  - Each op_valid cycle (op_ready=1): register op_a/op_b onto mac_a/mac_b and decrement count.
  - Each cycle without op_valid: register NOP operands 8'h00/8'h00, which contribute exactly 0. Count holds.
  - When the last pair is accepted (count==1 && op_valid), go to DRAIN.
- DRAIN: one cycle with NOP operands driven, so the last pair is accumulated.
- READ_LO: mac_out_hl=0. mac_out is captured into res_data[15:0] at the cycle's end.
- READ_HI: mac_out_hl=1. mac_out is captured into res_data[31:16].
- DONE:
  - res_valid=1 and mac_a/mac_b held at NOP.
  - On res_ready, go to IDLE with res_valid=0 on the next cycle.
  - res_data holds its value until the next job's READ_LO.
- Whenever the state is not RUN, mac_a/mac_b equal NOP, so the MAC accumulator is stable outside RUN and DRAIN.
- No arithmetic is done in this block. Overflow wraps modulo 2^32 inside the MAC and is reported unchanged.
- start while busy: ignored (start_ready=0). op_valid outside RUN: ignored (op_ready=0).

## Timing
- All outputs are registered except start_ready, op_ready and busy, which are decoded from the state.
- Reset values:
  - state=IDLE, mac_reset=1, mac_a=mac_b=8'h00, mac_out_hl=1
  - res_valid=0, res_data=0, count=0
- mac_reset is 1 while reset is high, and 0 from the first cycle after reset falls, except in CLEAR.
- mac_out_hl idles at 1. Every READ_LO therefore produces a 1→0 transition and READ_HI produces 0→1.
- Back-to-back operands with start accepted at cycle 0:
  - CLEAR at cycle 1
  - RUN at cycles 2..N+1
  - DRAIN at N+2
  - READ_LO at N+3, READ_HI at N+4
  - res_valid at N+5
- Each stall cycle in RUN adds exactly one cycle to this timeline.
- N=0: CLEAR at 1, DRAIN at 2, READ_LO at 3, READ_HI at 4, res_valid at 5 with res_data=0.
- res_ready may be held high before res_valid rises. DONE then lasts exactly one cycle.
- Earliest next start acceptance is the cycle after DONE exits.
- Reset mid-job, in any state: state=IDLE and all outputs take their reset values on the next edge. The pending job and result are discarded. mac_reset=1 clears the MAC on the same edge.

## Structure
- Shared package tpu_pkg holds:
  - the state enum
  - the constant MAC_NOP = 8'h00
  - the default LEN_W
  - the result width 32 and half width 16
- No sub-module; a single FSM with a count register and an output register bank. The MAC is instantiated alongside this block, not inside it.

## Test plan
- Reset then N=3, three back-to-back pairs (8'h08, 8'h08) -> res_data=32'h000000C0, res_valid first high at cycle 8 after start.
- N=2, pairs (8'h88, 8'h08), (8'h08, 8'h08) -> res_data=32'h00000000. N=1, pair (8'h88, 8'h08) -> 32'hFFFFFFC0.
- N=1, pair (8'h50, 8'h50) -> res_data=32'h01000000; checks that the high half is captured correctly.
- N=4 with op_valid low for 3 random cycles -> each gap shows op_ready=1 and mac_a=mac_b=0; result equals the no-stall sum; res_valid is 3 cycles later than the no-stall case.
- N=0 -> res_data=0 at cycle 5. Then hold res_ready=0 for 10 cycles -> res_valid stays 1 and res_data stays stable, and start is refused.
- Reset asserted in RUN after 2 of 5 pairs, then a new job N=1 (8'h08, 8'h08) -> res_data=32'h00000040, with no residue from the aborted job.
